// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multi-cycle ALU slice.
//   alu_op_t    : opcode encoding carried on ALUControl. It keeps the
//                 single-cycle ALU codes and adds MUL.
//   alu_state_t : sequencing state of alu_mc (IDLE or iterating MUL).
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SUB   = 4'b0110,
        OP_PASSB = 4'b0111,
        OP_MUL   = 4'b1000
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational ALU for the single-cycle opcodes.
// Ports:
//   a, b      : N-bit operands
//   op        : 4-bit opcode (alu_op_t encoding)
//   result    : N-bit result (0 for MUL and for undefined codes)
//   zero      : result == 0
//   negative  : result MSB
//   carry     : carry-out of ADD / no-borrow of SUB, else 0
//   overflow  : signed overflow of ADD / SUB, else 0
//   illegal   : op is not a defined opcode
// MUL is sequenced by alu_mc. Here MUL only counts as a legal code.
// ---------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         negative,
    output logic         carry,
    output logic         overflow,
    output logic         illegal
);

    logic         is_sub;
    logic [N-1:0] b_add;
    logic [N:0]   sum;

    always_comb begin
        // SUB shares the adder as a + ~b + 1, so carry out means "no borrow".
        is_sub = (op == OP_SUB);
        b_add  = is_sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_add} + {{N{1'b0}}, is_sub};

        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        illegal  = 1'b0;

        case (op)
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_ADD, OP_SUB: begin
                result   = sum[N-1:0];
                carry    = sum[N];
                // For SUB b_add is ~b, so this one test covers both rules.
                overflow = (a[N-1] == b_add[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_PASSB: result = b;
            OP_MUL:   result = '0;
            default:  illegal = 1'b1;
        endcase

        zero     = (result == '0);
        negative = result[N-1];
    end

endmodule

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc
// Multi-cycle ALU for the execute stage. It uses a start/done handshake and
// registered NZCV flags.
// Ports:
//   clk, reset   : clock (rising edge), async active-high reset
//   start        : request, sampled only while IDLE
//   a, b         : N-bit operands, sampled at the accepting edge
//   ALUControl   : opcode, sampled at the accepting edge
//   busy         : high while a MUL iterates
//   done         : one-cycle pulse when result/flags were just written
//   result       : registered result
//   zero, negative, carry, overflow : registered flags
//   illegal      : last accepted opcode was undefined
// Single-cycle ops complete at the accepting edge. MUL runs shift-and-add,
// one partial product per edge, and finishes N edges after acceptance.
// ---------------------------------------------------------------------------
module alu_mc
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ALUControl,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         negative,
    output logic         carry,
    output logic         overflow,
    output logic         illegal
);

    localparam int CW = $clog2(N);

    alu_state_t   state_q, state_d;
    logic [N-1:0] mcand_q, mcand_d;
    logic [N-1:0] mplier_q, mplier_d;
    logic [N-1:0] acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0] result_q, result_d;
    logic         zero_q, zero_d;
    logic         negative_q, negative_d;
    logic         carry_q, carry_d;
    logic         overflow_q, overflow_d;
    logic         illegal_q, illegal_d;
    logic         done_q, done_d;

    logic [N-1:0] core_result;
    logic         core_zero, core_negative, core_carry, core_overflow, core_illegal;
    logic [N-1:0] acc_next;

    alu_core #(.N(N)) u_core (
        .a        (a),
        .b        (b),
        .op       (ALUControl),
        .result   (core_result),
        .zero     (core_zero),
        .negative (core_negative),
        .carry    (core_carry),
        .overflow (core_overflow),
        .illegal  (core_illegal)
    );

    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        count_d    = count_q;
        result_d   = result_q;
        zero_d     = zero_q;
        negative_d = negative_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
        done_d     = 1'b0;

        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ALUControl == OP_MUL) begin
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = MUL;
                    end else begin
                        result_d   = core_result;
                        zero_d     = core_zero;
                        negative_d = core_negative;
                        carry_d    = core_carry;
                        overflow_d = core_overflow;
                        illegal_d  = core_illegal;
                        done_d     = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                // The last iteration writes the fresh sum straight to result.
                if (count_q == CW'(N - 1)) begin
                    result_d   = acc_next;
                    zero_d     = (acc_next == '0);
                    negative_d = acc_next[N-1];
                    carry_d    = 1'b0;
                    overflow_d = 1'b0;
                    illegal_d  = 1'b0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == MUL);
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign negative = negative_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc
// Self-checking bench for alu_mc (N = 64). This file contains the directed
// cases, a randomized mix of opcodes, and a reference model built from
// plain arithmetic.
// ---------------------------------------------------------------------------
module tb_alu_mc;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   aluControl;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         zero;
    logic         negative;
    logic         carry;
    logic         overflow;
    logic         illegal;

    int totalChecks = 0;
    int badChecks   = 0;

    // Outputs the bench expects the DUT to be holding right now.
    logic [N-1:0] expRes;
    logic         expZ, expN, expC, expV, expIll;

    alu_mc #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .ALUControl (aluControl),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .zero       (zero),
        .negative   (negative),
        .carry      (carry),
        .overflow   (overflow),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [N-1:0] observed,
                               input logic [N-1:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference model that applies the ALU rules with ordinary arithmetic.
    task automatic modelOp(input logic [3:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N-1:0] r;
        logic c, v, ill;
        c = 1'b0; v = 1'b0; ill = 1'b0;
        case (op)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: begin
                r = x + y;
                c = (r < x);
                v = ($signed(x) < 0) == ($signed(y) < 0) && (($signed(r) < 0) != ($signed(x) < 0));
            end
            4'b0110: begin
                r = x - y;
                c = (x >= y);
                v = (($signed(x) < 0) != ($signed(y) < 0)) && (($signed(r) < 0) != ($signed(x) < 0));
            end
            4'b0111: r = y;
            4'b1000: r = x * y;
            default: begin r = '0; ill = 1'b1; end
        endcase
        expRes = r;
        expZ   = (r == 0);
        expN   = ($signed(r) < 0);
        expC   = c;
        expV   = v;
        expIll = ill;
    endtask

    task automatic checkHeld(input string tag);
        checkOutput({tag, " result"},   result,   expRes);
        checkOutput({tag, " zero"},     zero,     expZ);
        checkOutput({tag, " negative"}, negative, expN);
        checkOutput({tag, " carry"},    carry,    expC);
        checkOutput({tag, " overflow"}, overflow, expV);
        checkOutput({tag, " illegal"},  illegal,  expIll);
    endtask

    // Single-cycle op: called at posedge+1. It returns at posedge+1 after the accepting edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
        start = 1'b1; aluControl = op; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~x; b = ~y; aluControl = ~op;
        modelOp(op, x, y);
        checkOutput("single done", done, 1'b1);
        checkOutput("single busy", busy, 1'b0);
        checkHeld("single");
    endtask

    // MUL: optionally pulses an ADD start at edge k+10 that must be ignored.
    task automatic applyMul(input logic [N-1:0] x, input logic [N-1:0] y, input bit inject);
        int n;
        start = 1'b1; aluControl = 4'b1000; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = '0; b = '0; aluControl = 4'b0010;
        checkOutput("mul accept busy", busy, 1'b1);
        checkOutput("mul accept done", done, 1'b0);
        n = 0;
        do begin
            n++;
            start = inject && (n == 10);
            if (start) begin aluControl = 4'b0010; a = 1; b = 1; end
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) begin
                checkOutput("mul hold result", result, expRes);
                checkOutput("mul hold done", done, 1'b0);
            end
        end while (busy && n < 200);
        checkOutput("mul busy cycles", n, N);
        checkOutput("mul done", done, 1'b1);
        modelOp(4'b1000, x, y);
        checkHeld("mul");
        @(posedge clk); #1;
        checkOutput("mul done pulse width", done, 1'b0);
        checkOutput("mul busy after", busy, 1'b0);
    endtask

    function automatic logic [N-1:0] randOperand();
        logic [N-1:0] v;
        case ($urandom_range(0, 4))
            0: v = '0;
            1: v = '1;
            2: v = {1'b1, {(N-1){1'b0}}};
            3: v = N'($urandom_range(0, 1000));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        int dones;
        logic [3:0] legalOps [6];
        logic [3:0] op;
        legalOps = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000};

        reset = 1'b1; start = 1'b0; a = '0; b = '0; aluControl = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset result", result, '0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset zero", zero, 1'b0);
        checkOutput("reset illegal", illegal, 1'b0);
        expRes = '0; expZ = 0; expN = 0; expC = 0; expV = 0; expIll = 0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        applyStimulus(4'b0010, 239, 26);
        checkOutput("add 239+26", result, 265);
        applyStimulus(4'b0110, 5, 5);
        applyStimulus(4'b0110, 0, -635);
        checkOutput("sub 0-(-635)", result, 635);
        applyStimulus(4'b0110, -98, -407);
        checkOutput("sub carry", carry, 1'b1);
        applyStimulus(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 1);
        checkOutput("add ovf V", overflow, 1'b1);
        applyStimulus(4'b0010, '1, 1);
        checkOutput("add -1+1 C", carry, 1'b1);
        applyStimulus(4'b1111, 930, -33);
        checkOutput("illegal flag", illegal, 1'b1);
        applyStimulus(4'b0001, 930, -33);
        checkOutput("or result", result, '1);

        applyMul(593, 26, 1'b1);
        checkOutput("mul 593*26", result, 15418);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 9) < 7) op = legalOps[$urandom_range(0, 5)];
            else op = 4'($urandom);
            if (op == 4'b1000) applyMul(randOperand(), randOperand(), 1'($urandom));
            else applyStimulus(op, randOperand(), randOperand());
        end

        // Abort a MUL with an asynchronous mid-cycle reset.
        start = 1'b1; aluControl = 4'b1000; a = 3; b = 7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        checkOutput("abort busy before", busy, 1'b1);
        #1 reset = 1'b1;
        #1;
        checkOutput("abort busy", busy, 1'b0);
        checkOutput("abort done", done, 1'b0);
        checkOutput("abort result", result, '0);
        expRes = '0; expZ = 0; expN = 0; expC = 0; expV = 0; expIll = 0;
        @(negedge clk); reset = 1'b0;
        dones = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        checkOutput("abort no done", dones, 0);
        applyStimulus(4'b0010, 1, 2);
        checkOutput("after abort 1+2", result, 3);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
